// File: rtl/uart_pkg.sv
// Shared definitions for the camera-link UART command receiver:
// default timing and framing constants plus the byte- and packet-FSM state types.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 1085;    // 125 MHz / 115200 baud
    localparam logic [7:0]  HEADER_BYTE_DEF  = 8'hA5;
    localparam int unsigned TIMEOUT_CLKS_DEF = 125000;  // 1 ms inter-byte limit

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } byte_state_e;

    typedef enum logic [1:0] {
        P_HDR,
        P_CMD,
        P_DATA,
        P_CHK
    } pkt_state_e;

    // Packet checksum: XOR of the command and data bytes.
    function automatic logic [7:0] pkt_checksum(input logic [7:0] cmd, input logic [7:0] data);
        return cmd ^ data;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: two-flop synchroniser on the serial line followed by the
// byte FSM (IDLE/START/DATA/STOP/WAIT_HIGH). Samples mid-bit, LSB first.
// Emits a one-cycle valid pulse with the byte, or a one-cycle frame-error pulse.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    byte_state_e      state_q,   state_d;
    logic             rx_meta_q, rx_meta_d;
    logic             rx_s_q,    rx_s_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q,   shreg_d;
    logic [7:0]       byte_q,    byte_d;
    logic             valid_q,   valid_d;
    logic             ferr_q,    ferr_d;

    // State register: synchroniser resets to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    // Next-state: bit timing, shifting and stop-bit validation.
    always_comb begin
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        byte_d    = byte_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = IDLE;   // too short to be a start bit
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s_q, shreg_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        byte_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_HIGH: begin
                // A held-low line (break) must not be mistaken for a new start bit.
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: registered pulses and byte, busy decoded from state.
    always_comb begin
        rx_byte       = byte_q;
        rx_byte_valid = valid_q;
        frame_err     = ferr_q;
        busy          = (state_q != IDLE);
    end

endmodule

// File: rtl/uart_cmd_rx.sv
// Host-to-FPGA command receiver for the camera serial link.
// Byte reception is delegated to uart_rx_byte; this level parses 4-byte
// packets {HEADER_BYTE, cmd, data, cmd^data} and presents validated commands.
// Optional inter-byte packet timeout: define UART_CMD_RX_TIMEOUT_EN.
module uart_cmd_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter logic [7:0]  HEADER_BYTE  = HEADER_BYTE_DEF,
    parameter int unsigned TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
    input  logic       Clk,
    input  logic       i_Rst_n,
    input  logic       i_RX,
    output logic [7:0] o_Byte,
    output logic       o_Byte_Valid,
    output logic [7:0] o_Cmd,
    output logic [7:0] o_Data,
    output logic       o_Cmd_Valid,
    output logic       o_Frame_Err,
    output logic       o_Chk_Err,
    output logic       o_Timeout,
    output logic       o_Busy
);

    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       frame_err;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_byte (
        .clk          (Clk),
        .rst_n        (i_Rst_n),
        .rx           (i_RX),
        .rx_byte      (rx_byte),
        .rx_byte_valid(rx_byte_valid),
        .frame_err    (frame_err),
        .busy         (o_Busy)
    );

    pkt_state_e pstate_q,    pstate_d;
    logic [7:0] cmd_lat_q,   cmd_lat_d;
    logic [7:0] data_lat_q,  data_lat_d;
    logic [7:0] cmd_q,       cmd_d;
    logic [7:0] data_q,      data_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic       chk_err_q,   chk_err_d;

`ifdef UART_CMD_RX_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

    logic [TO_W-1:0] to_cnt_q,  to_cnt_d;
    logic            timeout_q, timeout_d;
`endif

    // State register for the packet parser and its output holding flops.
    always_ff @(posedge Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            pstate_q    <= P_HDR;
            cmd_lat_q   <= '0;
            data_lat_q  <= '0;
            cmd_q       <= '0;
            data_q      <= '0;
            cmd_valid_q <= 1'b0;
            chk_err_q   <= 1'b0;
`ifdef UART_CMD_RX_TIMEOUT_EN
            to_cnt_q    <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            pstate_q    <= pstate_d;
            cmd_lat_q   <= cmd_lat_d;
            data_lat_q  <= data_lat_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            cmd_valid_q <= cmd_valid_d;
            chk_err_q   <= chk_err_d;
`ifdef UART_CMD_RX_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    // Next-state: advance on each received byte; a frame error drops the partial packet.
    always_comb begin
        pstate_d    = pstate_q;
        cmd_lat_d   = cmd_lat_q;
        data_lat_d  = data_lat_q;
        cmd_d       = cmd_q;
        data_d      = data_q;
        cmd_valid_d = 1'b0;
        chk_err_d   = 1'b0;
        if (frame_err) begin
            pstate_d = P_HDR;
        end else if (rx_byte_valid) begin
            unique case (pstate_q)
                P_HDR: begin
                    if (rx_byte == HEADER_BYTE) begin
                        pstate_d = P_CMD;
                    end
                end
                P_CMD: begin
                    cmd_lat_d = rx_byte;
                    pstate_d  = P_DATA;
                end
                P_DATA: begin
                    data_lat_d = rx_byte;
                    pstate_d   = P_CHK;
                end
                P_CHK: begin
                    if (rx_byte == pkt_checksum(cmd_lat_q, data_lat_q)) begin
                        cmd_d       = cmd_lat_q;
                        data_d      = data_lat_q;
                        cmd_valid_d = 1'b1;
                    end else begin
                        chk_err_d = 1'b1;
                    end
                    pstate_d = P_HDR;
                end
                default: pstate_d = P_HDR;
            endcase
        end
`ifdef UART_CMD_RX_TIMEOUT_EN
        // A byte arriving on the expiry cycle takes priority over the timeout.
        to_cnt_d  = to_cnt_q;
        timeout_d = 1'b0;
        if (rx_byte_valid || (pstate_q == P_HDR)) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
            to_cnt_d  = '0;
            timeout_d = 1'b1;
            pstate_d  = P_HDR;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
    end

    // Outputs: byte-level signals pass through, packet-level from holding flops.
    always_comb begin
        o_Byte       = rx_byte;
        o_Byte_Valid = rx_byte_valid;
        o_Frame_Err  = frame_err;
        o_Cmd        = cmd_q;
        o_Data       = data_q;
        o_Cmd_Valid  = cmd_valid_q;
        o_Chk_Err    = chk_err_q;
`ifdef UART_CMD_RX_TIMEOUT_EN
        o_Timeout    = timeout_q;
`else
        // No timeout logic in this build; the parameter stays on the interface for overrides.
        o_Timeout    = (TIMEOUT_CLKS == 0) & 1'b0;
`endif
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: table of byte bursts with hand-computed
// expected pulse counts and command outputs, plus sequences for glitch,
// reset-abort and packet-timeout behaviour.
module tb_uart_cmd_rx;

    localparam int unsigned CPB = 16;
    localparam int unsigned TO  = 2000;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] o_Byte;
    logic       o_Byte_Valid;
    logic [7:0] o_Cmd;
    logic [7:0] o_Data;
    logic       o_Cmd_Valid;
    logic       o_Frame_Err;
    logic       o_Chk_Err;
    logic       o_Timeout;
    logic       o_Busy;

    uart_cmd_rx #(
        .CLKS_PER_BIT(CPB),
        .HEADER_BYTE (8'hA5),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .Clk         (clk),
        .i_Rst_n     (rst_n),
        .i_RX        (rx),
        .o_Byte      (o_Byte),
        .o_Byte_Valid(o_Byte_Valid),
        .o_Cmd       (o_Cmd),
        .o_Data      (o_Data),
        .o_Cmd_Valid (o_Cmd_Valid),
        .o_Frame_Err (o_Frame_Err),
        .o_Chk_Err   (o_Chk_Err),
        .o_Timeout   (o_Timeout),
        .o_Busy      (o_Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Pulse monitor, sampled on the falling edge.
    int         n_bv = 0, n_cv = 0, n_fe = 0, n_ce = 0, n_to = 0, n_ov1 = 0, n_ov2 = 0;
    logic [7:0] last_byte = 8'h00;

    always @(negedge clk) begin
        if (o_Byte_Valid) begin
            n_bv      <= n_bv + 1;
            last_byte <= o_Byte;
        end
        if (o_Cmd_Valid) n_cv <= n_cv + 1;
        if (o_Frame_Err) n_fe <= n_fe + 1;
        if (o_Chk_Err)   n_ce <= n_ce + 1;
        if (o_Timeout)   n_to <= n_to + 1;
        if (o_Byte_Valid && o_Frame_Err) n_ov1 <= n_ov1 + 1;
        if (o_Cmd_Valid && (o_Chk_Err || o_Frame_Err || o_Timeout)) n_ov2 <= n_ov2 + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        rx = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(CPB);
        end
        rx = stop_ok;
        wait_clks(CPB);
        rx = 1'b1;
        wait_clks(2 * CPB);
    endtask

    function automatic logic [29:0] all_outs();
        return {o_Byte, o_Byte_Valid, o_Cmd, o_Data, o_Cmd_Valid,
                o_Frame_Err, o_Chk_Err, o_Timeout, o_Busy};
    endfunction

    typedef struct {
        int unsigned n;
        logic [63:0] bytes;     // byte i at [8*i +: 8]
        logic [7:0]  stop_ok;   // bit i: stop bit of byte i driven high
        int          exp_bv;
        int          exp_cv;
        int          exp_ce;
        int          exp_fe;
        logic [7:0]  exp_last;
        logic [7:0]  exp_cmd;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[7];

    // Watchdog: the run is fully time-deterministic, so this only trips on a hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int bv0, cv0, fe0, ce0, to0;
        logic [63:0] bb;
        logic [7:0]  so;

        vecs[0] = '{1, 64'h55,               8'hFF, 1, 0, 0, 0, 8'h55, 8'h00, 8'h00};
        vecs[1] = '{4, 64'h7C7F03A5,         8'hFF, 4, 1, 0, 0, 8'h7C, 8'h03, 8'h7F};
        vecs[2] = '{4, 64'h332211A5,         8'hFF, 4, 1, 0, 0, 8'h33, 8'h11, 8'h22};
        vecs[3] = '{4, 64'h007F03A5,         8'hFF, 4, 0, 1, 0, 8'h00, 8'h11, 8'h22};
        vecs[4] = '{7, 64'h00302010A54403A5, 8'hFB, 6, 1, 0, 1, 8'h30, 8'h10, 8'h20};
        vecs[5] = '{4, 64'hA207A5A5,         8'hFF, 4, 1, 0, 0, 8'hA2, 8'hA5, 8'h07};
        vecs[6] = '{6, 64'hFFF00FA5FF00,     8'hFF, 6, 1, 0, 0, 8'hFF, 8'h0F, 8'hF0};

        rx    = 1'b1;
        rst_n = 1'b0;
        wait_clks(4);
        check("reset_outputs", 32'(all_outs()), 32'h0);
        rst_n = 1'b1;
        wait_clks(4 * CPB);

        for (int v = 0; v < 7; v++) begin
            bv0 = n_bv; cv0 = n_cv; fe0 = n_fe; ce0 = n_ce;
            bb  = vecs[v].bytes;
            so  = vecs[v].stop_ok;
            for (int i = 0; i < int'(vecs[v].n); i++) begin
                send_byte(bb[8*i +: 8], so[i]);
            end
            wait_clks(2 * CPB);
            check($sformatf("v%0d_byte_valid_cnt", v), 32'(n_bv - bv0), 32'(vecs[v].exp_bv));
            check($sformatf("v%0d_last_byte", v),      32'(last_byte),  32'(vecs[v].exp_last));
            check($sformatf("v%0d_cmd_valid_cnt", v),  32'(n_cv - cv0), 32'(vecs[v].exp_cv));
            check($sformatf("v%0d_chk_err_cnt", v),    32'(n_ce - ce0), 32'(vecs[v].exp_ce));
            check($sformatf("v%0d_frame_err_cnt", v),  32'(n_fe - fe0), 32'(vecs[v].exp_fe));
            check($sformatf("v%0d_cmd", v),            32'(o_Cmd),      32'(vecs[v].exp_cmd));
            check($sformatf("v%0d_data", v),           32'(o_Data),     32'(vecs[v].exp_data));
            check($sformatf("v%0d_busy_idle", v),      32'(o_Busy),     32'h0);
        end

        // Short low glitch on an idle line: rejected by the start-bit check.
        bv0 = n_bv; fe0 = n_fe;
        rx = 1'b0;
        wait_clks(4);
        check("glitch_busy_high", 32'(o_Busy), 32'h1);
        rx = 1'b1;
        wait_clks(3 * CPB);
        check("glitch_no_byte",  32'(n_bv - bv0), 32'h0);
        check("glitch_no_ferr",  32'(n_fe - fe0), 32'h0);
        check("glitch_busy_low", 32'(o_Busy),     32'h0);

        // Partial packet followed by a long pause.
        cv0 = n_cv; to0 = n_to;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        wait_clks(TO + 100);
`ifdef UART_CMD_RX_TIMEOUT_EN
        check("timeout_pulse_cnt", 32'(n_to - to0), 32'h1);
        send_byte(8'h7F, 1'b1);
        send_byte(8'h7C, 1'b1);
        wait_clks(CPB);
        check("timeout_tail_ignored", 32'(n_cv - cv0), 32'h0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        wait_clks(CPB);
        check("timeout_next_cmd_cnt", 32'(n_cv - cv0), 32'h1);
        check("timeout_next_cmd",     32'(o_Cmd),      32'h01);
        check("timeout_next_data",    32'(o_Data),     32'h02);
`else
        check("no_timeout_pulse", 32'(n_to - to0), 32'h0);
        send_byte(8'h7F, 1'b1);
        send_byte(8'h7C, 1'b1);
        wait_clks(CPB);
        check("late_pkt_cmd_cnt", 32'(n_cv - cv0), 32'h1);
        check("late_pkt_cmd",     32'(o_Cmd),      32'h03);
        check("late_pkt_data",    32'(o_Data),     32'h7F);
`endif

        // Reset in the middle of a byte: abort, all outputs cleared, no pulses.
        bv0 = n_bv; fe0 = n_fe;
        rx = 1'b0; wait_clks(CPB);
        rx = 1'b1; wait_clks(CPB);
        rx = 1'b0; wait_clks(CPB);
        rst_n = 1'b0;
        wait_clks(1);
        check("midbyte_reset_outputs", 32'(all_outs()), 32'h0);
        rx = 1'b1;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(12 * CPB);
        check("midbyte_no_byte", 32'(n_bv - bv0), 32'h0);
        check("midbyte_no_ferr", 32'(n_fe - fe0), 32'h0);

        // Reset in the middle of a packet: the remainder must not complete a command.
        cv0 = n_cv; ce0 = n_ce;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        rst_n = 1'b0;
        wait_clks(2);
        rst_n = 1'b1;
        wait_clks(CPB);
        send_byte(8'h7F, 1'b1);
        send_byte(8'h7C, 1'b1);
        wait_clks(CPB);
        check("midpkt_no_cmd",     32'(n_cv - cv0), 32'h0);
        check("midpkt_no_chk_err", 32'(n_ce - ce0), 32'h0);
        check("midpkt_cmd_clear",  32'(o_Cmd),      32'h0);
        check("midpkt_last_byte",  32'(last_byte),  32'h7C);

        check("overlap_bv_ferr",   32'(n_ov1), 32'h0);
        check("overlap_cmd_error", 32'(n_ov2), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
- UART receiver for the host-to-FPGA direction of the camera serial link; the companion of the frame transmitter on the same line.
- Deserialises 8N1 bytes on i_RX (115200 baud at 125 MHz) and parses 4-byte command packets: header, cmd, data, checksum.
- Validated commands go to the capture control logic, e.g. to re-arm capture or select the frame mode.

Parameters:
- CLKS_PER_BIT, 1085, Clk cycles per UART bit.
- HEADER_BYTE, 8'hA5, first byte of every packet.
- TIMEOUT_CLKS, 125000, inter-byte timeout in Clk cycles; used only with the optional feature.

Ports:
- Clk  input  1  system clock
- i_Rst_n  input  1  reset; asynchronous, active-low
- i_RX  input  1  asynchronous serial line; idles high
- o_Byte  output  8  last received byte
- o_Byte_Valid  output  1  one-cycle pulse when o_Byte updates
- o_Cmd  output  8  command of last valid packet
- o_Data  output  8  data of last valid packet
- o_Cmd_Valid  output  1  one-cycle pulse when o_Cmd/o_Data update
- o_Frame_Err  output  1  one-cycle pulse on a bad stop bit
- o_Chk_Err  output  1  one-cycle pulse on a checksum mismatch
- o_Timeout  output  1  one-cycle pulse on packet timeout; tied 0 without the macro
- o_Busy  output  1  high while the byte FSM is not in IDLE

Behaviour:
- Reset (async, i_Rst_n=0): all outputs 0; both i_RX synchroniser flops set to 1; both FSMs to their first state; all counters 0.
- Input sync: i_RX passes through 2 flops (rx_s); all decisions use rx_s.
- Byte FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. Bit counter cnt runs 0..CLKS_PER_BIT-1.
- IDLE: rx_s=0 moves to START with cnt=0.
- START: at cnt=CLKS_PER_BIT/2-1, sample rx_s.
  - 0: go to DATA, cnt=0, bit index 0.
  - 1: glitch; return to IDLE with no output.
- DATA: at cnt=CLKS_PER_BIT-1, sample one bit into the shift register, LSB first. After bit 7, go to STOP.
- STOP: at cnt=CLKS_PER_BIT-1, sample rx_s.
  - 1: the next cycle o_Byte is loaded and o_Byte_Valid pulses; return to IDLE.
  - 0: o_Frame_Err pulses, byte discarded; go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s=1, then go to IDLE. A line held low (break) does not retrigger.
- o_Byte_Valid and o_Frame_Err never assert in the same cycle.
- Packet FSM states: P_HDR, P_CMD, P_DATA, P_CHK. It advances only on o_Byte_Valid.
  - P_HDR: a byte equal to HEADER_BYTE moves to P_CMD; any other byte is ignored.
  - P_CMD: latch cmd, go to P_DATA.
  - P_DATA: latch data, go to P_CHK.
  - P_CHK: if byte == cmd XOR data, the next cycle o_Cmd/o_Data update and o_Cmd_Valid pulses; otherwise o_Chk_Err pulses and outputs hold. Both cases return to P_HDR.
- Header byte arriving mid-packet: treated as ordinary cmd/data/chk content; no resync.
- o_Frame_Err in any packet state: packet FSM returns to P_HDR and the partial packet is discarded.
- Error pulses never coincide with o_Cmd_Valid.
- Latency from the stop-bit sample: o_Byte_Valid +1 cycle; o_Cmd_Valid +1 cycle after the checksum byte's o_Byte_Valid.
- Reset mid-byte or mid-packet: immediate abort; no pulses emitted.

Optional Feature:
- Macro: UART_CMD_RX_TIMEOUT_EN.
- Defined:
  - A timeout counter clears on every o_Byte_Valid and counts while the packet FSM is not in P_HDR.
  - On reaching TIMEOUT_CLKS-1, the packet FSM returns to P_HDR and o_Timeout pulses for one cycle.
  - If timeout and o_Byte_Valid coincide, the byte wins: the counter clears and no timeout fires.
- Undefined: no counter exists, o_Timeout is constant 0, and partial packets wait indefinitely.

Decomposition:
- Shared package uart_pkg holds:
  - CLKS_PER_BIT default
  - HEADER_BYTE
  - TIMEOUT_CLKS
  - byte-FSM and packet-FSM state encodings (localparams)
- One sub-module, uart_rx_byte: synchroniser plus byte FSM, driving o_Byte, o_Byte_Valid, o_Frame_Err and o_Busy. uart_cmd_rx instantiates it and adds the packet parser.

Test Plan:
- Serialise 0x55 at 1085 clk/bit on an idle-high line -> exactly one o_Byte_Valid with o_Byte=0x55; no error pulses; o_Busy returns to 0.
- Bytes A5 03 7F 7C -> one o_Cmd_Valid with o_Cmd=0x03 and o_Data=0x7F; o_Chk_Err stays 0.
- Bytes A5 03 7F 00 -> one o_Chk_Err; no o_Cmd_Valid; o_Cmd/o_Data keep their previous values.
- Bytes A5 03, then a byte with stop bit=0, then A5 10 20 30 -> o_Frame_Err once, then o_Cmd_Valid with Cmd=0x10, Data=0x20.
- Low glitch of 300 clk on an idle line, then i_Rst_n pulsed low mid-byte -> no o_Byte_Valid, no o_Frame_Err; all outputs 0 during reset.
- Macro defined: A5 03, then 125000 clk of silence -> o_Timeout pulse; following 7F 7C ignored; next A5 01 02 03 -> o_Cmd_Valid.
